// File: rtl/linefill_db.sv
// Linefill data buffer: collects downstream refill beats per line entry in a
// single-port buffer, then streams completed lines into the data SRAM write port
// and reports completion to the MSHR/ROB.
// Optional protocol checking is compiled in with `define LINEFILL_DB_PROTO_CHK_EN.
module linefill_db #(
    parameter int unsigned ENTRY_NUM      = 8,
    parameter int unsigned BEATS_PER_LINE = 4,
    parameter int unsigned DATA_WIDTH     = 1024,
    parameter int unsigned ROB_IDX_WIDTH  = 6,
    parameter int unsigned TXNID_WIDTH    = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    output logic                              alloc_vld,
    output logic [$clog2(ENTRY_NUM)-1:0]      alloc_idx,
    input  logic                              alloc_rdy,
    input  logic [ROB_IDX_WIDTH-1:0]          alloc_rob_id,
    input  logic                              ds_vld,
    output logic                              ds_rdy,
    input  logic [$clog2(ENTRY_NUM)-1:0]      ds_entry_idx,
    input  logic [TXNID_WIDTH-1:0]            ds_txnid,
    input  logic                              ds_last,
    input  logic [DATA_WIDTH-1:0]             ds_data,
    output logic                              ram_wr_vld,
    input  logic                              ram_wr_rdy,
    output logic [$clog2(ENTRY_NUM)-1:0]      ram_wr_entry_idx,
    output logic [$clog2(BEATS_PER_LINE)-1:0] ram_wr_beat,
    output logic [ROB_IDX_WIDTH-1:0]          ram_wr_rob_id,
    output logic [DATA_WIDTH-1:0]             ram_wr_data,
    output logic                              linefill_done,
    output logic [ROB_IDX_WIDTH-1:0]          linefill_done_idx,
    output logic                              proto_err
);

    localparam int unsigned EW = $clog2(ENTRY_NUM);
    localparam int unsigned BW = $clog2(BEATS_PER_LINE);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS_PER_LINE - 1);

    typedef enum logic [1:0] {StIdle, StFilling, StFull, StDraining} ent_state_e;

    ent_state_e              state_q    [ENTRY_NUM];
    ent_state_e              state_d    [ENTRY_NUM];
    logic [BW-1:0]           beat_cnt_q [ENTRY_NUM];
    logic [ROB_IDX_WIDTH-1:0] rob_id_q  [ENTRY_NUM];
    logic [TXNID_WIDTH-1:0]  txnid_q    [ENTRY_NUM];
    logic [ENTRY_NUM-1:0]    idle_vec;
    logic [ENTRY_NUM-1:0]    filling_vec;

    logic [DATA_WIDTH-1:0]   mem [ENTRY_NUM * BEATS_PER_LINE];

    logic [EW-1:0]           fifo_q [ENTRY_NUM];
    logic [EW:0]             wptr_q, rptr_q;
    logic                    fifo_empty;
    logic [EW-1:0]           fifo_head;

    logic                    drain_busy_q;
    logic [EW-1:0]           drain_entry_q;
    logic [BW-1:0]           rd_beat_q;
    logic                    out_vld_q;
    logic [EW-1:0]           out_entry_q;
    logic [BW-1:0]           out_beat_q;
    logic [DATA_WIDTH-1:0]   out_data_q;

    logic                    alloc_hs;
    logic                    tgt_filling;
    logic [BW-1:0]           cur_cnt;
    logic                    wrap;
    logic                    ds_wr;
    logic                    ds_full;
    logic [EW-1:0]           cur_entry;
    logic [BW-1:0]           cur_beat;
    logic                    rd_en;
    logic                    pop;
    logic                    out_fire;
    logic                    done_fire;
    logic                    unused_txnid;

    assign alloc_hs    = alloc_vld & alloc_rdy;
    assign tgt_filling = filling_vec[ds_entry_idx];
    assign cur_cnt     = beat_cnt_q[ds_entry_idx];
    assign wrap        = ds_last | (cur_cnt == LAST_BEAT);

`ifdef LINEFILL_DB_PROTO_CHK_EN
    // Beats to entries not being filled are dropped; early ds_last is flagged but honoured
    assign ds_wr     = ds_vld & tgt_filling;
    assign proto_err = ds_vld & (~tgt_filling | (ds_last & (cur_cnt != LAST_BEAT)));
`else
    assign ds_wr     = ds_vld;
    assign proto_err = 1'b0;
`endif

    // Only a filling entry may go FULL, which keeps the drain FIFO from overflowing
    assign ds_full = ds_wr & tgt_filling & wrap;

    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_head  = fifo_q[rptr_q[EW-1:0]];

    // When idle the engine reads beat 0 of the FIFO head in the same cycle it pops it
    assign cur_entry = drain_busy_q ? drain_entry_q : fifo_head;
    assign cur_beat  = drain_busy_q ? rd_beat_q : '0;
    assign out_fire  = out_vld_q & ram_wr_rdy;
    assign rd_en     = (drain_busy_q | ~fifo_empty) & ~ds_wr & (~out_vld_q | ram_wr_rdy);
    assign pop       = rd_en & ~drain_busy_q;
    assign done_fire = out_fire & (out_beat_q == LAST_BEAT);

    assign ds_rdy            = 1'b1;
    assign ram_wr_vld        = out_vld_q;
    assign ram_wr_entry_idx  = out_entry_q;
    assign ram_wr_beat       = out_beat_q;
    assign ram_wr_rob_id     = rob_id_q[out_entry_q];
    assign ram_wr_data       = out_data_q;
    assign linefill_done     = done_fire;
    assign linefill_done_idx = rob_id_q[out_entry_q];

    // Lowest-index idle entry is offered for allocation
    always_comb begin
        alloc_idx = '0;
        for (int i = int'(ENTRY_NUM) - 1; i >= 0; i--) begin
            if (idle_vec[i]) alloc_idx = EW'(i);
        end
        alloc_vld = |idle_vec;
    end

    // Entry state register
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(ENTRY_NUM); i++) begin
            if (!rst_n) state_q[i] <= StIdle;
            else        state_q[i] <= state_d[i];
        end
    end

    // Entry next-state logic
    always_comb begin
        for (int i = 0; i < int'(ENTRY_NUM); i++) begin
            state_d[i] = state_q[i];
            unique case (state_q[i])
                StIdle:     if (alloc_hs && alloc_idx == EW'(i))       state_d[i] = StFilling;
                StFilling:  if (ds_full && ds_entry_idx == EW'(i))     state_d[i] = StFull;
                StFull:     if (pop && fifo_head == EW'(i))            state_d[i] = StDraining;
                StDraining: if (done_fire && out_entry_q == EW'(i))    state_d[i] = StIdle;
                default:    state_d[i] = StIdle;
            endcase
        end
    end

    // Entry state decode
    always_comb begin
        for (int i = 0; i < int'(ENTRY_NUM); i++) begin
            idle_vec[i]    = (state_q[i] == StIdle);
            filling_vec[i] = (state_q[i] == StFilling);
        end
    end

    // Per-entry beat counter, bound ROB id and transaction id
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(ENTRY_NUM); i++) begin
            if (!rst_n) begin
                beat_cnt_q[i] <= '0;
                rob_id_q[i]   <= '0;
                txnid_q[i]    <= '0;
            end else if (alloc_hs && alloc_idx == EW'(i)) begin
                beat_cnt_q[i] <= '0;
                rob_id_q[i]   <= alloc_rob_id;
            end else if (ds_wr && ds_entry_idx == EW'(i)) begin
                beat_cnt_q[i] <= wrap ? '0 : beat_cnt_q[i] + 1'b1;
                if (beat_cnt_q[i] == '0) txnid_q[i] <= ds_txnid;
            end
        end
    end

    // Transaction id is retained for debug visibility only
    always_comb begin
        unused_txnid = 1'b0;
        for (int i = 0; i < int'(ENTRY_NUM); i++) unused_txnid = unused_txnid ^ (^txnid_q[i]);
    end

    // Single-port buffer: fill writes win, drain reads land in the output register
    always_ff @(posedge clk) begin
        if (ds_wr) mem[{ds_entry_idx, cur_cnt}] <= ds_data;
        if (rd_en) out_data_q <= mem[{cur_entry, cur_beat}];
    end

    // Drain FIFO storage
    always_ff @(posedge clk) begin
        if (ds_full) fifo_q[wptr_q[EW-1:0]] <= ds_entry_idx;
    end

    // Drain FIFO pointers, read sequencer and output register control
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q        <= '0;
            rptr_q        <= '0;
            drain_busy_q  <= 1'b0;
            drain_entry_q <= '0;
            rd_beat_q     <= '0;
            out_vld_q     <= 1'b0;
            out_entry_q   <= '0;
            out_beat_q    <= '0;
        end else begin
            if (ds_full) wptr_q <= wptr_q + 1'b1;
            if (pop)     rptr_q <= rptr_q + 1'b1;
            if (rd_en) begin
                drain_busy_q  <= (cur_beat != LAST_BEAT);
                drain_entry_q <= cur_entry;
                rd_beat_q     <= cur_beat + 1'b1;
                out_vld_q     <= 1'b1;
                out_entry_q   <= cur_entry;
                out_beat_q    <= cur_beat;
            end else if (out_fire) begin
                out_vld_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_linefill_db.sv
// Self-checking bench for linefill_db: cycle vector table plus directed sequences.
module tb_linefill_db;

    localparam int DW = 1024;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          alloc_vld;
    logic [2:0]    alloc_idx;
    logic          alloc_rdy;
    logic [5:0]    alloc_rob_id;
    logic          ds_vld;
    logic          ds_rdy;
    logic [2:0]    ds_entry_idx;
    logic [7:0]    ds_txnid;
    logic          ds_last;
    logic [DW-1:0] ds_data;
    logic          ram_wr_vld;
    logic          ram_wr_rdy;
    logic [2:0]    ram_wr_entry_idx;
    logic [1:0]    ram_wr_beat;
    logic [5:0]    ram_wr_rob_id;
    logic [DW-1:0] ram_wr_data;
    logic          linefill_done;
    logic [5:0]    linefill_done_idx;
    logic          proto_err;

    linefill_db dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .alloc_vld         (alloc_vld),
        .alloc_idx         (alloc_idx),
        .alloc_rdy         (alloc_rdy),
        .alloc_rob_id      (alloc_rob_id),
        .ds_vld            (ds_vld),
        .ds_rdy            (ds_rdy),
        .ds_entry_idx      (ds_entry_idx),
        .ds_txnid          (ds_txnid),
        .ds_last           (ds_last),
        .ds_data           (ds_data),
        .ram_wr_vld        (ram_wr_vld),
        .ram_wr_rdy        (ram_wr_rdy),
        .ram_wr_entry_idx  (ram_wr_entry_idx),
        .ram_wr_beat       (ram_wr_beat),
        .ram_wr_rob_id     (ram_wr_rob_id),
        .ram_wr_data       (ram_wr_data),
        .linefill_done     (linefill_done),
        .linefill_done_idx (linefill_done_idx),
        .proto_err         (proto_err)
    );

    always #5 clk = ~clk;

`ifdef LINEFILL_DB_PROTO_CHK_EN
    localparam logic PERR = 1'b1;
`else
    localparam logic PERR = 1'b0;
`endif

    typedef struct {
        logic       ar;  logic [5:0] rob;
        logic       dv;  logic [2:0] di; logic dl; logic [7:0] dd;
        logic       rdy;
        logic       av;  logic [2:0] ai;
        logic       wv;  logic [1:0] wb; logic [2:0] we; logic [7:0] wd;
        logic       dn;  logic [5:0] dix;
    } vec_t;

    vec_t vecs[$];
    int   passed = 0;
    int   total  = 0;

    function automatic void add(logic ar, logic [5:0] rob, logic dv, logic [2:0] di, logic dl,
                                logic [7:0] dd, logic rdy, logic av, logic [2:0] ai, logic wv,
                                logic [1:0] wb, logic [2:0] we, logic [7:0] wd, logic dn,
                                logic [5:0] dix);
        vecs.push_back('{ar, rob, dv, di, dl, dd, rdy, av, ai, wv, wb, we, wd, dn, dix});
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ds_beat(input logic [2:0] e, input logic l, input logic [7:0] d);
        ds_vld       = 1'b1;
        ds_entry_idx = e;
        ds_last      = l;
        ds_data      = '0;
        ds_data[7:0] = d;
    endtask

    // Waits (bounded) for a full line drain; checks beat order, entry, data and completion
    task automatic drain_line(input logic [7:0] base, input int nk, input logic [5:0] rob,
                              input logic [2:0] ent);
        int nb = 0;
        bit got = 0;
        ds_vld     = 1'b0;
        ram_wr_rdy = 1'b1;
        for (int c = 0; c < 30 && !got; c++) begin
            #2;
            if (ram_wr_vld) begin
                chk("drain_beat", 64'(ram_wr_beat), 64'(nb));
                chk("drain_entry", 64'(ram_wr_entry_idx), 64'(ent));
                chk("drain_rob", 64'(ram_wr_rob_id), 64'(rob));
                if (nb < nk) chk("drain_data", ram_wr_data[63:0], 64'(base + 8'(nb)));
                chk("drain_done", 64'(linefill_done), 64'(nb == 3));
                if (nb == 3) begin
                    chk("drain_done_idx", 64'(linefill_done_idx), 64'(rob));
                    got = 1;
                end
                nb++;
            end
            tick();
        end
        if (!got) begin
            total++;
            $display("FAIL drain_timeout: got %0d beats, expected 4", nb);
        end
    endtask

    initial begin
        rst_n = 1'b0; alloc_rdy = 1'b0; alloc_rob_id = '0; ds_vld = 1'b0; ds_entry_idx = '0;
        ds_txnid = 8'h3c; ds_last = 1'b0; ds_data = '0; ram_wr_rdy = 1'b1;

        // Scenario: alloc, fill entry 0, drain with backpressure on beat 1
        add(1,5, 0,0,0,8'h00, 1, 1,0, 0,0,0,8'h00, 0,0);
        add(0,0, 1,0,0,8'hA0, 1, 1,1, 0,0,0,8'h00, 0,0);
        add(0,0, 1,0,0,8'hA1, 1, 1,1, 0,0,0,8'h00, 0,0);
        add(0,0, 1,0,0,8'hA2, 1, 1,1, 0,0,0,8'h00, 0,0);
        add(0,0, 1,0,1,8'hA3, 1, 1,1, 0,0,0,8'h00, 0,0);
        add(0,0, 0,0,0,8'h00, 1, 1,1, 0,0,0,8'h00, 0,0);
        add(0,0, 0,0,0,8'h00, 1, 1,1, 1,0,0,8'hA0, 0,0);
        add(0,0, 0,0,0,8'h00, 0, 1,1, 1,1,0,8'hA1, 0,0);
        add(0,0, 0,0,0,8'h00, 0, 1,1, 1,1,0,8'hA1, 0,0);
        add(0,0, 0,0,0,8'h00, 0, 1,1, 1,1,0,8'hA1, 0,0);
        add(0,0, 0,0,0,8'h00, 1, 1,1, 1,1,0,8'hA1, 0,0);
        add(0,0, 0,0,0,8'h00, 1, 1,1, 1,2,0,8'hA2, 0,0);
        add(0,0, 0,0,0,8'h00, 1, 1,1, 1,3,0,8'hA3, 1,5);
        // Scenario: entries 0,1,2 with fill/drain collisions
        add(1,1, 0,0,0,8'h00, 1, 1,0, 0,0,0,8'h00, 0,0);
        add(1,2, 0,0,0,8'h00, 1, 1,1, 0,0,0,8'h00, 0,0);
        add(1,3, 0,0,0,8'h00, 1, 1,2, 0,0,0,8'h00, 0,0);
        add(0,0, 1,0,0,8'hB0, 1, 1,3, 0,0,0,8'h00, 0,0);
        add(0,0, 1,0,0,8'hB1, 1, 1,3, 0,0,0,8'h00, 0,0);
        add(0,0, 1,0,0,8'hB2, 1, 1,3, 0,0,0,8'h00, 0,0);
        add(0,0, 1,0,1,8'hB3, 1, 1,3, 0,0,0,8'h00, 0,0);
        add(0,0, 1,1,0,8'hC0, 1, 1,3, 0,0,0,8'h00, 0,0);
        add(0,0, 0,0,0,8'h00, 1, 1,3, 0,0,0,8'h00, 0,0);
        add(0,0, 1,1,0,8'hC1, 1, 1,3, 1,0,0,8'hB0, 0,0);
        add(0,0, 1,1,0,8'hC2, 1, 1,3, 0,0,0,8'h00, 0,0);
        add(0,0, 1,1,1,8'hC3, 1, 1,3, 0,0,0,8'h00, 0,0);
        add(0,0, 1,2,0,8'hD0, 1, 1,3, 0,0,0,8'h00, 0,0);
        add(0,0, 0,0,0,8'h00, 1, 1,3, 0,0,0,8'h00, 0,0);
        add(0,0, 1,2,0,8'hD1, 1, 1,3, 1,1,0,8'hB1, 0,0);
        add(0,0, 0,0,0,8'h00, 1, 1,3, 0,0,0,8'h00, 0,0);
        add(0,0, 0,0,0,8'h00, 1, 1,3, 1,2,0,8'hB2, 0,0);
        add(0,0, 1,2,0,8'hD2, 1, 1,3, 1,3,0,8'hB3, 1,1);
        add(0,0, 1,2,1,8'hD3, 1, 1,0, 0,0,0,8'h00, 0,0);
        add(0,0, 0,0,0,8'h00, 1, 1,0, 0,0,0,8'h00, 0,0);
        add(0,0, 0,0,0,8'h00, 1, 1,0, 1,0,1,8'hC0, 0,0);
        add(0,0, 0,0,0,8'h00, 1, 1,0, 1,1,1,8'hC1, 0,0);
        add(0,0, 0,0,0,8'h00, 1, 1,0, 1,2,1,8'hC2, 0,0);
        add(0,0, 0,0,0,8'h00, 1, 1,0, 1,3,1,8'hC3, 1,2);
        add(0,0, 0,0,0,8'h00, 1, 1,0, 1,0,2,8'hD0, 0,0);
        add(0,0, 0,0,0,8'h00, 1, 1,0, 1,1,2,8'hD1, 0,0);
        add(0,0, 0,0,0,8'h00, 1, 1,0, 1,2,2,8'hD2, 0,0);
        add(0,0, 0,0,0,8'h00, 1, 1,0, 1,3,2,8'hD3, 1,3);
        add(0,0, 0,0,0,8'h00, 1, 1,0, 0,0,0,8'h00, 0,0);

        // Reset state
        tick(); tick(); tick();
        #2;
        chk("rst_alloc", {62'(0), alloc_vld, alloc_idx[0]}, 64'h2);
        chk("rst_alloc_idx", 64'(alloc_idx), 64'd0);
        chk("rst_wr_vld", 64'(ram_wr_vld), 64'd0);
        chk("rst_done", 64'(linefill_done), 64'd0);
        chk("rst_perr", 64'(proto_err), 64'd0);
        chk("ds_rdy", 64'(ds_rdy), 64'd1);
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            alloc_rdy    = vecs[i].ar;
            alloc_rob_id = vecs[i].rob;
            if (vecs[i].dv) ds_beat(vecs[i].di, vecs[i].dl, vecs[i].dd);
            else            ds_vld = 1'b0;
            ram_wr_rdy   = vecs[i].rdy;
            #2;
            chk($sformatf("v%0d_alloc", i), 64'({alloc_vld, alloc_idx}),
                64'({vecs[i].av, vecs[i].ai}));
            chk($sformatf("v%0d_wr_vld", i), 64'(ram_wr_vld), 64'(vecs[i].wv));
            if (vecs[i].wv) begin
                chk($sformatf("v%0d_wr_beat", i), 64'({ram_wr_entry_idx, ram_wr_beat}),
                    64'({vecs[i].we, vecs[i].wb}));
                chk($sformatf("v%0d_wr_data", i), ram_wr_data[63:0], 64'(vecs[i].wd));
            end
            chk($sformatf("v%0d_done", i), 64'(linefill_done), 64'(vecs[i].dn));
            if (vecs[i].dn)
                chk($sformatf("v%0d_done_idx", i), 64'(linefill_done_idx), 64'(vecs[i].dix));
            chk($sformatf("v%0d_perr", i), 64'(proto_err), 64'd0);
            tick();
        end
        alloc_rdy = 1'b0;
        ds_vld    = 1'b0;

        // Allocate every entry, then free entry 3
        for (int i = 0; i < 8; i++) begin
            alloc_rdy    = 1'b1;
            alloc_rob_id = 6'(20 + i);
            #2;
            chk("fill_all_idx", 64'({alloc_vld, alloc_idx}), 64'({1'b1, 3'(i)}));
            tick();
        end
        alloc_rdy = 1'b0;
        #2;
        chk("all_busy_vld", 64'(alloc_vld), 64'd0);
        tick();
        for (int b = 0; b < 4; b++) begin
            ds_beat(3'd3, b == 3, 8'(8'hE0 + b));
            tick();
        end
        drain_line(8'hE0, 4, 6'd23, 3'd3);
        #2;
        chk("freed_alloc", 64'({alloc_vld, alloc_idx}), 64'({1'b1, 3'd3}));

        // Reset mid-operation, then a beat to an idle entry
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #2;
        chk("midrst_alloc", 64'({alloc_vld, alloc_idx}), 64'({1'b1, 3'd0}));
        chk("midrst_wr_vld", 64'(ram_wr_vld), 64'd0);
        tick();
        ds_beat(3'd6, 1'b0, 8'h55);
        #2;
        chk("idle_beat_perr", 64'(proto_err), 64'(PERR));
        chk("idle_beat_alloc", 64'({alloc_vld, alloc_idx}), 64'({1'b1, 3'd0}));
        tick();
        ds_vld = 1'b0;
        #2;
        chk("idle_beat_perr_clr", 64'(proto_err), 64'd0);
        chk("idle_beat_no_wr", 64'(ram_wr_vld), 64'd0);
        tick();
        for (int i = 0; i < 7; i++) begin
            alloc_rdy    = 1'b1;
            alloc_rob_id = 6'(30 + i);
            tick();
        end
        alloc_rdy = 1'b0;
        for (int b = 0; b < 4; b++) begin
            ds_beat(3'd6, b == 3, 8'(8'hF0 + b));
            tick();
        end
        drain_line(8'hF0, 4, 6'd36, 3'd6);

        // Early ds_last: flagged when checking is built in, line still completes
        alloc_rdy    = 1'b1;
        alloc_rob_id = 6'd40;
        #2;
        chk("realloc_idx", 64'({alloc_vld, alloc_idx}), 64'({1'b1, 3'd6}));
        tick();
        alloc_rdy = 1'b0;
        ds_beat(3'd6, 1'b1, 8'h77);
        #2;
        chk("early_last_perr", 64'(proto_err), 64'(PERR));
        tick();
        drain_line(8'h77, 1, 6'd40, 3'd6);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/linefill_db.md
Name: linefill_db

Overview:
- Linefill data buffer on the return path from downstream.
- Receives refill data beats for MSHR-allocated lines from downstream and stores them per line entry in a single-port buffer.
- Once a line is complete, streams its beats into the data SRAM write port, then signals line completion back to the MSHR/ROB.
- Counterpart of the evict buffer: that block moves SRAM data to downstream; this block moves downstream data into SRAM.

Parameters:
- ENTRY_NUM, 8, number of line entries; power of two.
- BEATS_PER_LINE, 4, data beats per line; power of two.
- DATA_WIDTH, 1024, bits per beat.
- ROB_IDX_WIDTH, 6, MSHR/ROB entry index width.
- TXNID_WIDTH, 8, downstream transaction id width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- alloc_vld  out  1  an idle entry is available.
- alloc_idx  out  $clog2(ENTRY_NUM)  lowest-index idle entry.
- alloc_rdy  in  1  MSHR takes alloc_idx this cycle.
- alloc_rob_id  in  ROB_IDX_WIDTH  ROB id bound to the allocated entry.
- ds_vld  in  1  downstream refill beat valid.
- ds_rdy  out  1  constant 1; no backpressure.
- ds_entry_idx  in  $clog2(ENTRY_NUM)  target entry.
- ds_txnid  in  TXNID_WIDTH  carried into the entry; not checked.
- ds_last  in  1  final beat of the line.
- ds_data  in  DATA_WIDTH  beat data.
- ram_wr_vld  out  1  SRAM write beat valid.
- ram_wr_rdy  in  1  SRAM accepts beat.
- ram_wr_entry_idx  out  $clog2(ENTRY_NUM)  entry being drained.
- ram_wr_beat  out  $clog2(BEATS_PER_LINE)  beat number within the line.
- ram_wr_rob_id  out  ROB_IDX_WIDTH  bound ROB id.
- ram_wr_data  out  DATA_WIDTH  beat data.
- linefill_done  out  1  one-cycle pulse: line fully written to SRAM.
- linefill_done_idx  out  ROB_IDX_WIDTH  ROB id of the completed line.
- proto_err  out  1  one-cycle pulse on an illegal beat (see Optional Feature).

Behaviour:
- Reset values: all entries IDLE, all beat counters 0, drain FIFO empty. Outputs: alloc_vld=1, alloc_idx=0, ram_wr_vld=0, linefill_done=0, proto_err=0.
- Entry FSM: IDLE -> FILLING on alloc handshake. FILLING -> FULL on an accepted beat with ds_last=1, or when the beat counter reaches BEATS_PER_LINE-1. FULL -> DRAINING when popped from the drain FIFO. DRAINING -> IDLE after the last beat is accepted by SRAM.
- Allocation: alloc_idx is a priority encode of IDLE entries. alloc_vld = any entry IDLE. An entry released in cycle N is visible to allocation in cycle N+1.
- Fill path: a beat writes memory address {ds_entry_idx, beat_cnt[ds_entry_idx]}; the per-entry counter then increments and wraps to 0 on FULL. ds_txnid is latched into the entry on its first beat.
- Drain FIFO: depth ENTRY_NUM, so it never overflows. An entry's index is pushed in the cycle the entry becomes FULL. Multiple entries cannot become FULL in the same cycle, since there is one ds beat per cycle.
- Drain engine: pops the FIFO head when idle and issues memory reads for beats 0..BEATS_PER_LINE-1 in order. Read data appears one cycle later in the output register, which drives ram_wr_*.
- Read issue condition: no ds write this cycle (writes have priority on the single memory port), AND the output register is empty or being consumed this cycle. Peak throughput is 1 beat per cycle.
- ram_wr_vld, once high, holds with a stable payload until ram_wr_rdy.
- Completion: when the last beat is accepted (ram_wr_vld & ram_wr_rdy & beat==BEATS_PER_LINE-1), the same cycle pulses linefill_done with linefill_done_idx = the entry's rob_id. The entry returns to IDLE on the next edge.
- Latency: with an idle drain engine and continuous rdy, ram_wr_vld for beat 0 rises 2 cycles after the last ds beat (FIFO push, then read).
- Reset mid-operation: every entry, counter, FIFO and output register clears; partially filled lines are discarded.

Optional Feature:
- Macro: LINEFILL_DB_PROTO_CHK_EN.
- Compiled in: a ds beat targeting a non-FILLING entry is dropped (no memory write, no counter change) and proto_err pulses in the same cycle. ds_last on a beat other than BEATS_PER_LINE-1 also pulses proto_err, but that beat is still written and the line still goes FULL.
- Compiled out: proto_err is tied to 0 and beats are written unconditionally.

Test Plan:
- Reset, then alloc_rdy=1 with rob_id=5 -> alloc_idx=0 granted. Next cycle alloc_idx=1, alloc_vld=1.
- Entry 0: 4 beats with data 0xA0..0xA3, ram_wr_rdy=1 -> ram_wr_vld rises 2 cycles after the last beat. Beats 0..3 carry 0xA0..0xA3. linefill_done=1 with idx=5 on the beat-3 handshake.
- Hold ram_wr_rdy=0 for 3 cycles during beat 1 -> beat 1 data stable throughout, no beat skipped, done only after beat 3.
- Fill entries 1 and 2 back-to-back while entry 0 drains, interleaving ds beats -> writes win each collision. Lines drain in FULL order 0,1,2 with correct data.
- Allocate all 8 entries -> alloc_vld=0. Complete entry 3 -> alloc_vld=1 with alloc_idx=3 the cycle after done.
- With LINEFILL_DB_PROTO_CHK_EN defined: beat to IDLE entry 6 -> proto_err=1, no state change. Without the macro: proto_err stays 0.
